// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit
// ----------------------------------------------------------------------------
// Instruction-fetch front end. Issues single-beat read requests to instruction
// memory (at most one outstanding) and stores the responses in a 2-entry
// prefetch FIFO of {pc, instr}. The FIFO head is presented combinationally to
// the decode stage. A redirect from EX flushes the FIFO and restarts fetching
// at the new target. A response that belongs to a flushed request is dropped.
//
// Optional feature (compile-time macro IF_FETCH_PERF_CNT_EN):
//   adds output bubble_cnt, a saturating count of cycles with if_valid=0.
//
// Parameters:
//   ADDR_W    width of all PC / address signals
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   imem_req     read request, one-cycle pulse
//   imem_addr    request address (valid with imem_req)
//   imem_rvalid  response strobe
//   imem_rdata   response instruction word
//   redirect     flush and refetch from redirect_pc
//   redirect_pc  redirect target
//   stall        decode holding; head entry is not consumed
//   if_valid     FIFO head valid
//   if_pc        PC of FIFO head (0 when empty)
//   if_instr     instruction of FIFO head (0 when empty)
//   bubble_cnt   (IF_FETCH_PERF_CNT_EN only) cycles with if_valid=0
// ============================================================================
module if_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_instr
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

    state_t            state_r;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] req_pc_r;

    logic [ADDR_W-1:0] fifo_pc_r    [2];
    logic [31:0]       fifo_instr_r [2];
    logic              rd_ptr_r;
    logic              wr_ptr_r;
    logic [1:0]        count_r;

    logic              head_valid_s;
    logic              pop_s;
    logic              push_s;
    logic [1:0]        occ_after_pop_s;
    logic              req_s;

    // Handshake decode: pop, push and request-issue conditions for this cycle
    always_comb begin
        head_valid_s    = (count_r != 2'd0);
        pop_s           = head_valid_s & ~stall;
        occ_after_pop_s = count_r - {1'b0, pop_s};
        // The request is gated with reset so nothing is issued while held in reset.
        req_s           = ~reset & (state_r == ST_IDLE) & ~redirect &
                          (occ_after_pop_s < 2'd2);
        // A response that coincides with a redirect belongs to the old stream.
        push_s          = (state_r == ST_WAIT) & imem_rvalid & ~redirect;
    end

    // Output drive: request and FIFO head; empty head reads as zero
    always_comb begin
        imem_req  = req_s;
        imem_addr = fetch_pc_r;
        if_valid  = head_valid_s;
        if_pc     = head_valid_s ? fifo_pc_r[rd_ptr_r]    : {ADDR_W{1'b0}};
        if_instr  = head_valid_s ? fifo_instr_r[rd_ptr_r] : 32'd0;
    end

    // Fetch FSM with fetch PC and outstanding-request PC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // imem_rvalid is ignored here: nothing is outstanding.
                    if (redirect) begin
                        fetch_pc_r <= redirect_pc;
                    end else if (req_s) begin
                        state_r    <= ST_WAIT;
                        req_pc_r   <= fetch_pc_r;
                        fetch_pc_r <= fetch_pc_r + PC_STEP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (redirect) begin
                        fetch_pc_r <= redirect_pc;
                        // If the response lands this cycle it is discarded and
                        // nothing remains outstanding; otherwise it must be dropped later.
                        state_r    <= imem_rvalid ? ST_IDLE : ST_DROP;
                    end else if (imem_rvalid) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DROP: begin
                    if (redirect) begin
                        fetch_pc_r <= redirect_pc;
                    end else begin
                        fetch_pc_r <= fetch_pc_r;
                    end
                    // Leaving on the stale response avoids waiting for a beat
                    // that will never come, even if a redirect arrives with it.
                    if (imem_rvalid) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DROP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Prefetch FIFO storage, pointers and occupancy; redirect flushes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_pc_r[0]    <= {ADDR_W{1'b0}};
            fifo_pc_r[1]    <= {ADDR_W{1'b0}};
            fifo_instr_r[0] <= 32'd0;
            fifo_instr_r[1] <= 32'd0;
            rd_ptr_r        <= 1'b0;
            wr_ptr_r        <= 1'b0;
            count_r         <= 2'd0;
        end else if (redirect) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_pc_r[wr_ptr_r]    <= req_pc_r;
                fifo_instr_r[wr_ptr_r] <= imem_rdata;
                wr_ptr_r               <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    // Saturating count of cycles in which decode sees no valid instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= 32'd0;
        end else if (!head_valid_s && (bubble_cnt != 32'hFFFF_FFFF)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end else begin
            bubble_cnt <= bubble_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// tb_if_fetch_unit
// ----------------------------------------------------------------------------
// Table-driven bench for if_fetch_unit (RESET_PC = 0x100). Each table row is
// one clock cycle: inputs are driven after the falling edge and the outputs
// are compared against hand-computed values before the next rising edge.
// The memory response is part of the row stimulus, so latency is explicit.
// Defining IF_FETCH_PERF_CNT_EN also checks bubble_cnt.
// ============================================================================
module tb_if_fetch_unit;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    int errors;
    int checks;
    int bub_exp;
    vec_t vecs[$];

    if_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
`ifdef IF_FETCH_PERF_CNT_EN
        ,
        .bubble_cnt  (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic rv, input logic [31:0] rdata,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic eval, input logic [31:0] epc,
                                input logic [31:0] einstr);
        vec_t v;
        v.stall = st;   v.redir = rd;     v.rpc = rpc;
        v.rvalid = rv;  v.rdata = rdata;
        v.e_req = ereq; v.e_addr = eaddr;
        v.e_valid = eval; v.e_pc = epc;   v.e_instr = einstr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called right after a falling edge; consumes exactly one rising edge.
    task automatic apply(input vec_t v, input int idx);
        stall       = v.stall;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        imem_rvalid = v.rvalid;
        imem_rdata  = v.rdata;
        #1;
        chk($sformatf("row%0d imem_req", idx), {31'd0, imem_req}, {31'd0, v.e_req});
        if (v.e_req) chk($sformatf("row%0d imem_addr", idx), imem_addr, v.e_addr);
        chk($sformatf("row%0d if_valid", idx), {31'd0, if_valid}, {31'd0, v.e_valid});
        if (v.e_valid) begin
            chk($sformatf("row%0d if_pc", idx), if_pc, v.e_pc);
            chk($sformatf("row%0d if_instr", idx), if_instr, v.e_instr);
        end
        if (!v.e_valid) bub_exp = bub_exp + 1;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " imem_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, " if_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, " if_pc"}, if_pc, 32'd0);
        chk({tag, " if_instr"}, if_instr, 32'd0);
`ifdef IF_FETCH_PERF_CNT_EN
        chk({tag, " bubble_cnt"}, bubble_cnt, 32'd0);
`endif
    endtask

    initial begin
        errors = 0; checks = 0; bub_exp = 0;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_rvalid = 1'b0; imem_rdata = 32'd0;

        // Sequential fetch from 0x100 with 1-cycle memory, then redirect while waiting
        vecs.push_back(mk(0,0,32'h0,0,32'h0,                 1,32'h100,0,32'h0,32'h0));
        vecs.push_back(mk(0,0,32'h0,1,32'hC0DE_0100,         0,32'h0,0,32'h0,32'h0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,                 1,32'h104,1,32'h100,32'hC0DE_0100));
        vecs.push_back(mk(0,0,32'h0,1,32'hC0DE_0104,         0,32'h0,0,32'h0,32'h0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,                 1,32'h108,1,32'h104,32'hC0DE_0104));
        vecs.push_back(mk(0,1,32'h200,0,32'h0,               0,32'h0,0,32'h0,32'h0));
        vecs.push_back(mk(0,0,32'h0,1,32'hC0DE_0108,         0,32'h0,0,32'h0,32'h0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,                 1,32'h200,0,32'h0,32'h0));
        vecs.push_back(mk(0,0,32'h0,1,32'hC0DE_0200,         0,32'h0,0,32'h0,32'h0));
        // Stall for 5 cycles: FIFO fills, requests stop, head holds 0x200
        vecs.push_back(mk(1,0,32'h0,0,32'h0,                 1,32'h204,1,32'h200,32'hC0DE_0200));
        vecs.push_back(mk(1,0,32'h0,1,32'hC0DE_0204,         0,32'h0,1,32'h200,32'hC0DE_0200));
        vecs.push_back(mk(1,0,32'h0,0,32'h0,                 0,32'h0,1,32'h200,32'hC0DE_0200));
        vecs.push_back(mk(1,0,32'h0,0,32'h0,                 0,32'h0,1,32'h200,32'hC0DE_0200));
        vecs.push_back(mk(1,0,32'h0,0,32'h0,                 0,32'h0,1,32'h200,32'hC0DE_0200));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,                 1,32'h208,1,32'h200,32'hC0DE_0200));
        // Redirect coincident with the response: response discarded, FIFO flushed
        vecs.push_back(mk(0,1,32'h300,1,32'hC0DE_0208,       0,32'h0,1,32'h204,32'hC0DE_0204));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,                 1,32'h300,0,32'h0,32'h0));
        vecs.push_back(mk(0,0,32'h0,1,32'hC0DE_0300,         0,32'h0,0,32'h0,32'h0));
        // Redirect in IDLE with a valid head, to the top of the address space
        vecs.push_back(mk(0,1,32'hFFFF_FFFC,0,32'h0,         0,32'h0,1,32'h300,32'hC0DE_0300));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,                 1,32'hFFFF_FFFC,0,32'h0,32'h0));
        vecs.push_back(mk(0,0,32'h0,1,32'hC0DE_FFFC,         0,32'h0,0,32'h0,32'h0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,                 1,32'h0,1,32'hFFFF_FFFC,32'hC0DE_FFFC));
        vecs.push_back(mk(0,0,32'h0,1,32'hC0DE_0000,         0,32'h0,0,32'h0,32'h0));
        // Fill under stall, spurious response in IDLE is ignored, then drain
        vecs.push_back(mk(1,0,32'h0,0,32'h0,                 1,32'h4,1,32'h0,32'hC0DE_0000));
        vecs.push_back(mk(1,0,32'h0,1,32'hC0DE_0004,         0,32'h0,1,32'h0,32'hC0DE_0000));
        vecs.push_back(mk(1,0,32'h0,1,32'hDEAD_BEEF,         0,32'h0,1,32'h0,32'hC0DE_0000));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,                 1,32'h8,1,32'h0,32'hC0DE_0000));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,                 0,32'h0,1,32'h4,32'hC0DE_0004));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,                 0,32'h0,0,32'h0,32'h0));
        vecs.push_back(mk(0,0,32'h0,1,32'hC0DE_0008,         0,32'h0,0,32'h0,32'h0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,                 1,32'hC,1,32'h8,32'hC0DE_0008));
        // Redirect in WAIT -> DROP, second redirect while in DROP retargets
        vecs.push_back(mk(0,1,32'h400,0,32'h0,               0,32'h0,0,32'h0,32'h0));
        vecs.push_back(mk(0,1,32'h500,0,32'h0,               0,32'h0,0,32'h0,32'h0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,                 0,32'h0,0,32'h0,32'h0));
        vecs.push_back(mk(0,0,32'h0,1,32'hC0DE_000C,         0,32'h0,0,32'h0,32'h0));
        vecs.push_back(mk(0,0,32'h0,0,32'h0,                 1,32'h500,0,32'h0,32'h0));

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

`ifdef IF_FETCH_PERF_CNT_EN
        chk("bubble_cnt table", bubble_cnt, bub_exp);
`endif

        // Reset while the 0x500 request is outstanding (asynchronous effect)
        stall = 1'b0; redirect = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        reset = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        bub_exp = 0;
        @(negedge clk);
        reset = 1'b0;
        // Late response after release arrives while IDLE: ignored, no push
        apply(mk(0,0,32'h0,1,32'hC0DE_0500,  1,32'h100,0,32'h0,32'h0), 100);
        apply(mk(0,0,32'h0,0,32'h0,          0,32'h0,0,32'h0,32'h0), 101);
        apply(mk(0,0,32'h0,1,32'hC0DE_0100,  0,32'h0,0,32'h0,32'h0), 102);
        apply(mk(1,0,32'h0,0,32'h0,          1,32'h104,1,32'h100,32'hC0DE_0100), 103);

`ifdef IF_FETCH_PERF_CNT_EN
        chk("bubble_cnt after reset", bubble_cnt, bub_exp);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
